// File: rtl/fuzz_program_loader.sv
// Write side of the fuzz harness fetch path: packs a big-endian byte stream into
// 32-bit instruction words, writes them to instruction memory, and tracks length/checksum.
module fuzz_program_loader #(
  parameter int         MAX_INSTRUCTIONS = 256,
  parameter int         ADDR_W           = 8,
  parameter logic [7:0] HALT_OPCODE      = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_partial,
  output logic [ADDR_W:0]   prog_len,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_INSTRUCTIONS);

  state_t      state;
  state_t      next_state;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic        last_seen;
  logic        accept;
  logic [31:0] word_next;

  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

  // s_ready is a registered decode of RECV, so it qualifies acceptance directly
  assign accept    = s_valid && s_ready;
  assign word_next = {word[23:0], s_data};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) next_state = RECV;
        else       next_state = state;
      end
      RECV: begin
        if (accept && (byte_idx == 2'd3)) begin
          if (prog_len == MAX_LEN) next_state = DONE;
          else                     next_state = WRITE;
        end else if (accept && s_last) begin
          next_state = DONE;
        end else begin
          next_state = RECV;
        end
      end
      WRITE: begin
        if ((word[31:24] == HALT_OPCODE) || last_seen) next_state = DONE;
        else                                           next_state = RECV;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs; status strobes are decoded from next_state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready      <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= {ADDR_W{1'b0}};
      imem_wdata   <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      err_partial  <= 1'b0;
      prog_len     <= {(ADDR_W+1){1'b0}};
      checksum     <= 32'd0;
      byte_idx     <= 2'd0;
      word         <= 32'd0;
      last_seen    <= 1'b0;
    end else begin
      s_ready <= (next_state == RECV);
      imem_we <= (next_state == WRITE);
      busy    <= (next_state == RECV) || (next_state == WRITE);
      done    <= (next_state == DONE);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            prog_len     <= {(ADDR_W+1){1'b0}};
            checksum     <= 32'd0;
            err_overflow <= 1'b0;
            err_partial  <= 1'b0;
            byte_idx     <= 2'd0;
            last_seen    <= 1'b0;
          end
        end
        RECV: begin
          if (accept) begin
            word     <= word_next;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              last_seen <= s_last;
              if (prog_len == MAX_LEN) begin
                err_overflow <= 1'b1;
              end else begin
                imem_addr  <= prog_len[ADDR_W-1:0];
                imem_wdata <= word_next;
              end
            end else if (s_last) begin
              err_partial <= 1'b1;
            end
          end
        end
        WRITE: begin
          prog_len <= prog_len + {{ADDR_W{1'b0}}, 1'b1};
          checksum <= rotl1(checksum) ^ word;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_program_loader.sv
// Randomized self-checking bench for fuzz_program_loader against a byte-stream
// reference model that computes the expected program image from the load rules.
module tb_fuzz_program_loader;
  localparam int MAX = 256;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          s_last = 1'b0;
  logic          s_ready, imem_we, busy, done, err_overflow, err_partial;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata, checksum;
  logic [AW:0]   prog_len;

  fuzz_program_loader #(.MAX_INSTRUCTIONS(MAX), .ADDR_W(AW), .HALT_OPCODE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err_overflow(err_overflow),
    .err_partial(err_partial), .prog_len(prog_len), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  stim_q[$];
  bit          use_last;
  logic [31:0] exp_w[$];
  logic [31:0] exp_cks;
  bit          exp_ovf, exp_part;
  int          exp_cons;
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  int          wr_bad;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every memory write; s_ready must be low and busy high during it
  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
      if (s_ready || !busy) wr_bad++;
    end
  end

  // Reference: walk the byte stream word by word applying the termination rules
  task automatic model();
    logic [31:0] w = 32'd0;
    int k = 0;
    bit stop = 0;
    exp_w.delete();
    exp_cks = 32'd0; exp_ovf = 0; exp_part = 0; exp_cons = 0;
    for (int i = 0; i < stim_q.size() && !stop; i++) begin
      bit lst = use_last && (i == stim_q.size() - 1);
      w = (w << 8) | {24'd0, stim_q[i]};
      k++;
      exp_cons++;
      if (k == 4) begin
        k = 0;
        if (exp_w.size() == MAX) begin
          exp_ovf = 1; stop = 1;
        end else begin
          exp_w.push_back(w);
          exp_cks = ((exp_cks << 1) | (exp_cks >> 31)) ^ w;
          if (w[31:24] == 8'hFF || lst) stop = 1;
        end
      end else if (lst) begin
        exp_part = 1; stop = 1;
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // mode 0: steady, 1: valid every other cycle, 2: random gaps
  task automatic drive(input int mode, input int stop_after, input bit pulse_start, output int consumed);
    int idx = 0;
    int cyc = 0;
    bit acc;
    consumed = 0;
    while (1) begin
      @(negedge clk);
      if (done || consumed >= stop_after || cyc >= 6000) break;
      s_valid = (idx < stim_q.size()) &&
                ((mode == 0) || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom % 3 != 0));
      s_data  = (idx < stim_q.size()) ? stim_q[idx] : 8'h00;
      s_last  = use_last && (idx == stim_q.size() - 1);
      start   = pulse_start && busy && ($urandom % 4 == 0);
      acc     = s_valid && s_ready;
      @(posedge clk);
      if (acc) begin idx++; consumed++; end
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
  endtask

  task automatic check_result(input string tag);
    check_val({tag, ".nwr"}, got_data.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_data.size(); i++) begin
      check_val({tag, ".addr"}, got_addr[i], i);
      check_val({tag, ".data"}, got_data[i], exp_w[i]);
    end
    check_val({tag, ".done"}, done, 1);
    check_val({tag, ".busy"}, busy, 0);
    check_val({tag, ".s_ready"}, s_ready, 0);
    check_val({tag, ".len"}, prog_len, exp_w.size());
    check_val({tag, ".cks"}, checksum, exp_cks);
    check_val({tag, ".ovf"}, err_overflow, exp_ovf);
    check_val({tag, ".part"}, err_partial, exp_part);
    check_val({tag, ".wr_rdy"}, wr_bad, 0);
  endtask

  task automatic run_load(input string tag, input int mode, input bit pulse_start);
    int cons;
    model();
    got_addr.delete(); got_data.delete(); wr_bad = 0;
    do_start();
    drive(mode, 1 << 30, pulse_start, cons);
    repeat (3) @(negedge clk);
    check_result(tag);
    check_val({tag, ".consumed"}, cons, exp_cons);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".ctl"}, {s_ready, imem_we, busy, done, err_overflow, err_partial}, 0);
    check_val({tag, ".addr"}, imem_addr, 0);
    check_val({tag, ".wdata"}, imem_wdata, 0);
    check_val({tag, ".len"}, prog_len, 0);
    check_val({tag, ".cks"}, checksum, 0);
  endtask

  initial begin
    int cons;
    #2 check_all_zero("reset");
    #10 rst_n = 1'b1;

    // Directed program ending in HALT
    stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03, 8'h04, 8'h00,
               8'hFF, 8'h00, 8'h00, 8'h00};
    use_last = 0;
    run_load("halt", 0, 0);
    check_val("halt.cks_const", checksum, 32'hFF060800);

    // Same program, gappy valid and start pulses while busy
    run_load("halt_gap", 1, 1);

    // 8 bytes, s_last on byte 8, no HALT
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    use_last = 1;
    run_load("last8", 0, 0);

    // s_last on 6th byte
    stim_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    run_load("partial", 2, 1);

    // HALT word whose last byte also carries s_last
    stim_q = '{8'h05, 8'h06, 8'h07, 8'h08, 8'hFF, 8'h01, 8'h02, 8'h03};
    run_load("halt_last", 0, 0);

    // 257 non-HALT words -> overflow
    stim_q.delete();
    for (int i = 0; i < 257 * 4; i++)
      stim_q.push_back((i % 4 == 0) ? 8'($urandom_range(0, 254)) : 8'($urandom));
    run_load("ovf", 0, 0);

    // Asynchronous reset between bytes 2 and 3 of word 1
    stim_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    use_last = 0;
    got_addr.delete(); got_data.delete();
    do_start();
    drive(0, 6, 0, cons);
    check_val("rst.pre_writes", got_data.size(), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk); @(negedge clk);
    check_val("rst.no_write", got_data.size(), 1);
    rst_n = 1'b1;
    stim_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hFF, 8'hEE, 8'hDD, 8'hCC};
    run_load("reload", 0, 0);

    // Random programs
    for (int t = 0; t < 12; t++) begin
      int sz = $urandom_range(1, 40);
      stim_q.delete();
      for (int i = 0; i < sz; i++) begin
        if (i % 4 == 0) stim_q.push_back(($urandom % 8 == 0) ? 8'hFF : 8'($urandom_range(0, 254)));
        else            stim_q.push_back(8'($urandom));
      end
      use_last = 1;
      run_load($sformatf("rand%0d", t), $urandom_range(0, 2), 1'($urandom % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fuzz_program_loader.md
Name: fuzz_program_loader

Overview:
Writes fuzz programs into the fuzz harness instruction memory; it is the write side of the harness fetch path. It accepts a byte stream with a valid/ready handshake and packs the bytes big-endian into 32-bit instruction words, so the opcode byte comes first. It writes each word through a single-port write interface and stops after a HALT word, at end of stream, or on overflow. It reports the program length and a running checksum so a testbench can cross-check against the Python-generated image.

Parameters:
MAX_INSTRUCTIONS, 256, depth of the target instruction memory in words.
ADDR_W, 8, instruction memory address width; must satisfy 2^ADDR_W >= MAX_INSTRUCTIONS.
HALT_OPCODE, 8'hFF, opcode value (bits [31:24]) that terminates a load. Tied to the generated HALT opcode at instantiation.

Ports:
clk  in  1  system clock, all state on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
s_valid  in  1  byte stream valid
s_data  in  8  byte stream data
s_last  in  1  marks the final byte of the stream; qualified by s_valid
s_ready  out  1  byte accepted when s_valid && s_ready
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_W  instruction memory write address
imem_wdata  out  32  instruction word
busy  out  1  high in RECV and WRITE
done  out  1  level; high in DONE until the next start or reset
err_overflow  out  1  a word arrived after MAX_INSTRUCTIONS words had been written
err_partial  out  1  s_last arrived on a byte that did not complete a word
prog_len  out  ADDR_W+1  number of words written, 0..MAX_INSTRUCTIONS
checksum  out  32  running checksum of written words

Behaviour:
- Reset values (async, immediate): state = IDLE; all outputs 0, including s_ready, imem_we, done, both errors, prog_len and checksum; byte index = 0; word shift register = 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE/DONE + start:
  - go to RECV next cycle;
  - clear prog_len, checksum, errors, done and the byte index.
- start is ignored in RECV and WRITE.
- RECV:
  - s_ready = 1.
  - Each accepted byte shifts in: word = {word[23:0], s_data}; byte index increments mod 4.
  - Accepting the 4th byte (index 3) moves to WRITE next cycle with the assembled word registered.
  - An accepted byte with s_last and index != 3 sets err_partial, goes to DONE and discards the partial word (no write).
- WRITE (exactly 1 cycle):
  - s_ready = 0; imem_we = 1; imem_addr = prog_len[ADDR_W-1:0]; imem_wdata = word.
  - The same edge updates:
    - prog_len += 1;
    - checksum = {checksum[30:0], checksum[31]} ^ word.
  - Next state is DONE if the word opcode == HALT_OPCODE or the completing byte carried s_last. Otherwise next state is RECV.
- Latency: the 4th byte is accepted on edge N; imem_we is high in cycle N+1 (from edge N to edge N+1). Peak throughput is 4 bytes per 5 cycles.
- Overflow: a word completing in RECV while prog_len == MAX_INSTRUCTIONS is not written. It sets err_overflow and goes to DONE.
- Zero-valued words are written like any other word and count in prog_len.
- HALT precedence: a HALT word that also carries s_last ends the load as a normal completion; no error.
- DONE:
  - s_ready = 0 and done = 1.
  - Any unconsumed stream bytes are left stalled.
  - Outputs hold until the next start.
- A reset mid-load aborts immediately. No further write occurs, and memory contents already written are not cleared.
- Only the low 8 bits of an index are ever compared; prog_len never wraps because it saturates via the overflow rule.

Test Plan:
- Start; bytes 01 00 00 00, 02 03 04 00, FF 00 00 00 → writes addr0 = 32'h01000000, addr1 = 32'h02030400, addr2 = 32'hFF000000. Then done = 1, prog_len = 3, no errors, checksum = rotl(rotl(01000000)^02030400)^FF000000.
- Stream of 8 bytes with s_last on byte 8 and no HALT → 2 writes, done = 1, prog_len = 2, err_partial = 0.
- s_last on the 6th byte → 1 write, err_partial = 1, done = 1, prog_len = 1.
- 257 non-HALT words with MAX_INSTRUCTIONS = 256 → 256 writes at addr 0..255, then err_overflow = 1, prog_len = 256, no 257th imem_we.
- s_valid toggling every other cycle, and start pulsed while busy → words identical to the steady-stream case, start ignored, s_ready low in every WRITE cycle.
- rst_n asserted asynchronously between bytes 2 and 3 of word 1 → all outputs 0 immediately, state IDLE; a new start reloads from addr 0.
